// File: rtl/sram_req_arbiter_pkg.sv
// rtl/sram_req_arbiter_pkg.sv - shared constants and types for the SRAM request arbiter
//
// Purpose : owner IDs recorded in the ID queue, FSM state encoding and
//           SRAM-like transfer size encodings.
// Ports   : none (package).
package sram_req_arbiter_pkg;

   // Owner IDs stored in the in-order return queue
   localparam logic ID_INST = 1'b0;
   localparam logic ID_DATA = 1'b1;

   // Grant FSM: IDLE picks a winner each cycle, HOLD_x locks the grant to x
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD_I = 2'd1,
      HOLD_D = 2'd2
   } arb_state_t;

   // Transfer size encodings
   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/arb_id_fifo.sv
// rtl/arb_id_fifo.sv - 1-bit wide in-order owner ID queue
//
// Purpose : circular buffer of DEPTH one-bit owner IDs; head/tail wrap
//           modulo DEPTH and cnt runs 0..DEPTH.
// Ports   : clk, resetn       clock, synchronous active-low reset
//           push, push_id     enqueue push_id at the tail
//           pop               dequeue the head (ignored when empty)
//           head              ID at the head of the queue
//           cnt               number of stored IDs
//           full, empty       cnt == DEPTH, cnt == 0
module arb_id_fifo #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic             push_id,
   input  logic             pop,
   output logic             head,
   output logic [CNT_W-1:0] cnt,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] id_mem;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (cnt == '0);
   assign full    = (cnt == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the head slot, so a push while full is legal then
   assign do_push = push & (~full | do_pop);
   assign head    = id_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            id_mem[wr_ptr] <= push_id;
            wr_ptr         <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (do_push && !do_pop) begin
            cnt <= cnt + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - shares one SRAM-like port between IF and EXE requesters
//
// Purpose : zero-cycle combinational grant of address phases, grant held
//           until the slave accepts, owner of every accepted transaction
//           queued in order so returned data_ok/rdata reach the right stage.
// Config  : SRAM_ARB_RR_EN defined -> round-robin on contention using a
//           last_grant register; undefined -> fixed data-over-inst priority.
// Ports   : clk, resetn                         clock, synchronous active-low reset
//           inst_req/addr -> inst_addr_ok       instruction address phase (read, word)
//           inst_data_ok, inst_rdata            instruction return
//           data_req/wr/size/wstrb/addr/wdata   data address phase
//           data_addr_ok                        data address phase accepted
//           data_data_ok, data_rdata            data return / write acknowledge
//           mem_req/wr/size/wstrb/addr/wdata    slave address phase
//           mem_addr_ok                         slave accepted address
//           mem_data_ok, mem_rdata              slave return, in acceptance order
module sram_req_arbiter
   import sram_req_arbiter_pkg::*;
#(
   parameter int MAX_OUTS = 2,
   parameter int OUTS_W   = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic              sel_data;
   logic              idle_win;
   logic              can_issue;
   logic              accept;
   logic              pop;
   logic              fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [OUTS_W-1:0] fifo_cnt;

   // Every mem_data_ok with something outstanding retires the head entry;
   // a pulse with nothing outstanding is dropped.
   assign pop = mem_data_ok & ~fifo_empty;

   // A return in the same cycle frees a slot, so a new grant may issue while full
   assign can_issue = ~fifo_full | pop;

`ifdef SRAM_ARB_RR_EN
   logic last_grant;

   // On contention the requester that did not win last time goes first
   assign idle_win = (inst_req & data_req) ? ~last_grant : data_req;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         last_grant <= ID_INST;
      end else if (accept) begin
         last_grant <= sel_data;
      end
   end
`else
   assign idle_win = data_req;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sel_data  = ID_INST;
      mem_req   = 1'b0;
      case (state)
         IDLE: begin
            sel_data = idle_win;
            mem_req  = can_issue & (inst_req | data_req);
            if (mem_req && !mem_addr_ok) begin
               state_nxt = idle_win ? HOLD_D : HOLD_I;
            end
         end
         HOLD_I: begin
            sel_data = ID_INST;
            mem_req  = inst_req;
            // Dropping a held request is illegal upstream; releasing here keeps the port from locking up
            if (mem_addr_ok || !inst_req) begin
               state_nxt = IDLE;
            end
         end
         HOLD_D: begin
            sel_data = ID_DATA;
            mem_req  = data_req;
            if (mem_addr_ok || !data_req) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign accept = mem_req & mem_addr_ok;

   // Instruction fetches are always word reads with no byte enables
   assign mem_wr    = sel_data ? data_wr    : 1'b0;
   assign mem_size  = sel_data ? data_size  : SIZE_W;
   assign mem_wstrb = sel_data ? data_wstrb : 4'h0;
   assign mem_addr  = sel_data ? data_addr  : inst_addr;
   assign mem_wdata = sel_data ? data_wdata : 32'h0;

   assign inst_addr_ok = accept & (sel_data == ID_INST);
   assign data_addr_ok = accept & (sel_data == ID_DATA);

   assign inst_data_ok = pop & (fifo_head == ID_INST);
   assign data_data_ok = pop & (fifo_head == ID_DATA);
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   arb_id_fifo #(
      .DEPTH (MAX_OUTS),
      .CNT_W (OUTS_W)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push    (accept),
      .push_id (sel_data),
      .pop     (pop),
      .head    (fifo_head),
      .cnt     (fifo_cnt),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // A return with nothing outstanding means the slave and arbiter disagree
   // (or a stale response after reset); it is dropped but worth noticing.
   a_no_orphan_return: assert property (@(posedge clk) disable iff (!resetn)
      mem_data_ok |-> (fifo_cnt != '0))
      else $warning("sram_req_arbiter: mem_data_ok with no outstanding transaction dropped");

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - self-checking bench for sram_req_arbiter
module tb_sram_req_arbiter;

   localparam int MAX_OUTS = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sram_req_arbiter #(.MAX_OUTS(MAX_OUTS), .OUTS_W(2)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   task automatic clear_inputs();
      inst_req = 1'b0; inst_addr = '0;
      data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk); clear_inputs(); resetn = 1'b0;
      @(negedge clk); resetn = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk); clear_inputs(); resetn = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'ha5a55a5a;
      @(negedge clk); resetn = 1'b1; #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req actual=%0h required=0", mem_req); end
      checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin failures++; $display("FAIL reset_addr_ok actual=%b required=00", {inst_addr_ok, data_addr_ok}); end
      checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL reset_data_ok actual=%b required=00", {inst_data_ok, data_data_ok}); end
      checks++; if (inst_rdata !== 32'ha5a55a5a || data_rdata !== 32'ha5a55a5a) begin failures++; $display("FAIL reset_rdata actual=%h/%h required=a5a55a5a", inst_rdata, data_rdata); end
      checks++; if (dut.u_fifo.cnt !== 2'd0) begin failures++; $display("FAIL reset_cnt actual=%0d required=0", dut.u_fifo.cnt); end
      @(negedge clk); mem_data_ok = 1'b0;
   endtask

   task automatic test_single_inst();
      @(negedge clk); clear_inputs(); inst_req = 1'b1; inst_addr = 32'h1c000000; mem_addr_ok = 1'b1; #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1c000000) begin failures++; $display("FAIL single_grant actual=%0h/%h required=1/1c000000", mem_req, mem_addr); end
      checks++; if (mem_wr !== 1'b0 || mem_size !== 2'd2 || mem_wstrb !== 4'h0) begin failures++; $display("FAIL single_fields actual=%0h/%0h/%0h required=0/2/0", mem_wr, mem_size, mem_wstrb); end
      checks++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin failures++; $display("FAIL single_addr_ok actual=%b%b required=10", inst_addr_ok, data_addr_ok); end
      @(negedge clk); inst_req = 1'b0; mem_addr_ok = 1'b0; #1;
      checks++; if (dut.u_fifo.cnt !== 2'd1) begin failures++; $display("FAIL single_cnt1 actual=%0d required=1", dut.u_fifo.cnt); end
      @(negedge clk);
      @(negedge clk); mem_data_ok = 1'b1; mem_rdata = 32'h02800c0c; #1;
      checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin failures++; $display("FAIL single_data_ok actual=%b%b required=10", inst_data_ok, data_data_ok); end
      checks++; if (inst_rdata !== 32'h02800c0c) begin failures++; $display("FAIL single_rdata actual=%h required=02800c0c", inst_rdata); end
      @(negedge clk); mem_data_ok = 1'b0; #1;
      checks++; if (dut.u_fifo.cnt !== 2'd0) begin failures++; $display("FAIL single_cnt0 actual=%0d required=0", dut.u_fifo.cnt); end
   endtask

   task automatic test_contention();
      @(negedge clk); clear_inputs();
      inst_req = 1'b1; inst_addr = 32'h1c000004;
      data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hf; data_addr = 32'h100; data_wdata = 32'hdeadbeef;
      mem_addr_ok = 1'b1; #1;
      checks++; if (mem_addr !== 32'h100 || mem_wr !== 1'b1 || mem_wdata !== 32'hdeadbeef || mem_wstrb !== 4'hf) begin failures++; $display("FAIL cont_first actual=%h/%0h/%h/%h required=100/1/deadbeef/f", mem_addr, mem_wr, mem_wdata, mem_wstrb); end
      checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin failures++; $display("FAIL cont_first_ok actual=%b%b required=01", inst_addr_ok, data_addr_ok); end
      @(negedge clk); data_req = 1'b0; #1;
      checks++; if (mem_addr !== 32'h1c000004 || inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin failures++; $display("FAIL cont_second actual=%h/%b%b required=1c000004/10", mem_addr, inst_addr_ok, data_addr_ok); end
      @(negedge clk); inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0; #1;
      checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin failures++; $display("FAIL cont_ret1 actual=%b%b required=01", inst_data_ok, data_data_ok); end
      @(negedge clk); mem_rdata = 32'h11; #1;
      checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin failures++; $display("FAIL cont_ret2 actual=%b%b required=10", inst_data_ok, data_data_ok); end
      @(negedge clk); mem_data_ok = 1'b0;
   endtask

   task automatic test_hold();
      @(negedge clk); clear_inputs(); inst_req = 1'b1; inst_addr = 32'h1c000010; #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1c000010) begin failures++; $display("FAIL hold_start actual=%0h/%h required=1/1c000010", mem_req, mem_addr); end
      for (int i = 1; i < 4; i++) begin
         @(negedge clk); data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h200; data_size = 2'd2; #1;
         checks++; if (dut.state !== sram_req_arbiter_pkg::HOLD_I) begin failures++; $display("FAIL hold_state cyc=%0d actual=%0d required=1", i, dut.state); end
         checks++; if (mem_addr !== 32'h1c000010 || data_addr_ok !== 1'b0 || inst_addr_ok !== 1'b0) begin failures++; $display("FAIL hold_lock cyc=%0d actual=%h/%b%b required=1c000010/00", i, mem_addr, inst_addr_ok, data_addr_ok); end
      end
      @(negedge clk); mem_addr_ok = 1'b1; #1;
      checks++; if (mem_addr !== 32'h1c000010 || inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin failures++; $display("FAIL hold_accept actual=%h/%b%b required=1c000010/10", mem_addr, inst_addr_ok, data_addr_ok); end
      @(negedge clk); inst_req = 1'b0; #1;
      checks++; if (mem_addr !== 32'h200 || data_addr_ok !== 1'b1) begin failures++; $display("FAIL hold_data actual=%h/%b required=200/1", mem_addr, data_addr_ok); end
      @(negedge clk); data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; #1;
      checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin failures++; $display("FAIL hold_ret1 actual=%b%b required=10", inst_data_ok, data_data_ok); end
      @(negedge clk); #1;
      checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b1) begin failures++; $display("FAIL hold_ret2 actual=%b%b required=01", inst_data_ok, data_data_ok); end
      @(negedge clk); mem_data_ok = 1'b0;
   endtask

   task automatic test_full();
      @(negedge clk); clear_inputs(); inst_req = 1'b1; inst_addr = 32'h1000; mem_addr_ok = 1'b1; #1;
      checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL full_acc0 actual=%b required=1", inst_addr_ok); end
      @(negedge clk); inst_addr = 32'h1004; #1;
      checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL full_acc1 actual=%b required=1", inst_addr_ok); end
      @(negedge clk); inst_addr = 32'h1008; #1;
      checks++; if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0) begin failures++; $display("FAIL full_block actual=%b/%b required=0/0", mem_req, inst_addr_ok); end
      checks++; if (dut.u_fifo.cnt !== 2'd2) begin failures++; $display("FAIL full_cnt actual=%0d required=2", dut.u_fifo.cnt); end
      @(negedge clk); mem_data_ok = 1'b1; mem_rdata = 32'h1111; #1;
      checks++; if (mem_req !== 1'b1 || inst_addr_ok !== 1'b1 || inst_data_ok !== 1'b1) begin failures++; $display("FAIL full_swap actual=%b/%b/%b required=1/1/1", mem_req, inst_addr_ok, inst_data_ok); end
      @(negedge clk); inst_req = 1'b0; #1;
      checks++; if (dut.u_fifo.cnt !== 2'd2) begin failures++; $display("FAIL full_cnt_after actual=%0d required=2", dut.u_fifo.cnt); end
      @(negedge clk);
      @(negedge clk); mem_data_ok = 1'b0; #1;
      checks++; if (dut.u_fifo.cnt !== 2'd0) begin failures++; $display("FAIL full_drain actual=%0d required=0", dut.u_fifo.cnt); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk); clear_inputs(); inst_req = 1'b1; inst_addr = 32'h2000; mem_addr_ok = 1'b1;
      @(negedge clk); inst_addr = 32'h2004;
      @(negedge clk); clear_inputs(); resetn = 1'b0;
      @(negedge clk); resetn = 1'b1;
      for (int i = 0; i < 2; i++) begin
         mem_data_ok = 1'b1; mem_rdata = 32'hcafe0000 + i; #1;
         checks++; if ({inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok, mem_req} !== 5'b0) begin failures++; $display("FAIL rstmid_quiet cyc=%0d actual=%b required=00000", i, {inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok, mem_req}); end
         @(negedge clk);
      end
      mem_data_ok = 1'b0;
   endtask

`ifdef SRAM_ARB_RR_EN
   task automatic test_rr();
      do_reset();
      inst_req = 1'b1; inst_addr = 32'h3000; data_req = 1'b1; data_addr = 32'h4000; mem_addr_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (data_addr_ok !== ((i % 2) == 0) || inst_addr_ok !== ((i % 2) == 1)) begin failures++; $display("FAIL rr_alt cyc=%0d actual=%b%b required=%b%b", i, inst_addr_ok, data_addr_ok, (i % 2) == 1, (i % 2) == 0); end
         @(negedge clk); mem_data_ok = 1'b1;
      end
      clear_inputs();
      @(negedge clk);
   endtask
`endif

   // Randomised traffic against a queue-based model of ownership and grant rules
   task automatic test_random();
      bit q[$];
      int held = -1;
      bit ip = 0, dp = 0;
      bit room, pop_e, req_e, acc_e;
      int win;
`ifdef SRAM_ARB_RR_EN
      int last_grant = 0;
`endif
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!ip && $urandom_range(0, 1) == 1) begin ip = 1; inst_addr = $urandom & 32'hfffffffc; end
         if (!dp && $urandom_range(0, 1) == 1) begin
            dp = 1; data_wr = 1'($urandom); data_size = 2'($urandom_range(0, 2));
            data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
         end
         inst_req = ip; data_req = dp;
         mem_addr_ok = ($urandom_range(0, 3) != 0);
         mem_data_ok = ($urandom_range(0, 2) == 0);
         mem_rdata = $urandom;
         #1;
         pop_e = mem_data_ok && (q.size() > 0);
         room  = (q.size() < MAX_OUTS) || pop_e;
         if (held >= 0) begin
            win = held; req_e = (held == 1) ? dp : ip;
         end else if (room && (ip || dp)) begin
`ifdef SRAM_ARB_RR_EN
            if (ip && dp) win = (last_grant == 1) ? 0 : 1;
            else win = dp ? 1 : 0;
`else
            win = dp ? 1 : 0;
`endif
            req_e = 1;
         end else begin
            win = 0; req_e = 0;
         end
         acc_e = req_e && mem_addr_ok;
         checks++; if (mem_req !== req_e) begin failures++; $display("FAIL rand_mem_req cyc=%0d actual=%b required=%b", cyc, mem_req, req_e); end
         if (req_e) begin
            checks++;
            if (win == 1 && (mem_addr !== data_addr || mem_wr !== data_wr || mem_size !== data_size || mem_wstrb !== data_wstrb || mem_wdata !== data_wdata)) begin
               failures++; $display("FAIL rand_data_fields cyc=%0d actual=%h/%b/%0d/%h/%h required=%h/%b/%0d/%h/%h", cyc, mem_addr, mem_wr, mem_size, mem_wstrb, mem_wdata, data_addr, data_wr, data_size, data_wstrb, data_wdata);
            end else if (win == 0 && (mem_addr !== inst_addr || mem_wr !== 1'b0 || mem_size !== 2'd2 || mem_wstrb !== 4'h0)) begin
               failures++; $display("FAIL rand_inst_fields cyc=%0d actual=%h/%b/%0d/%h required=%h/0/2/0", cyc, mem_addr, mem_wr, mem_size, mem_wstrb, inst_addr);
            end
         end
         checks++; if (inst_addr_ok !== (acc_e && win == 0) || data_addr_ok !== (acc_e && win == 1)) begin failures++; $display("FAIL rand_addr_ok cyc=%0d actual=%b%b required=%b%b", cyc, inst_addr_ok, data_addr_ok, acc_e && win == 0, acc_e && win == 1); end
         checks++; if (inst_data_ok !== (pop_e && q[0] == 1'b0) || data_data_ok !== (pop_e && q[0] == 1'b1)) begin failures++; $display("FAIL rand_data_ok cyc=%0d actual=%b%b required=%b%b", cyc, inst_data_ok, data_data_ok, pop_e && q[0] == 1'b0, pop_e && q[0] == 1'b1); end
         checks++; if (inst_rdata !== mem_rdata || data_rdata !== mem_rdata) begin failures++; $display("FAIL rand_rdata cyc=%0d actual=%h/%h required=%h", cyc, inst_rdata, data_rdata, mem_rdata); end
         if (pop_e) void'(q.pop_front());
         if (acc_e) begin
            q.push_back(win[0]); held = -1;
            if (win == 1) dp = 0; else ip = 0;
`ifdef SRAM_ARB_RR_EN
            last_grant = win;
`endif
         end else if (req_e) begin
            held = win;
         end
         @(negedge clk);
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      resetn = 1'b0;
      test_reset();
      test_single_inst();
      test_contention();
      test_hold();
      test_full();
      test_reset_mid();
`ifdef SRAM_ARB_RR_EN
      test_rr();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
